// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the redirect, instruction-memory and decode signals of
// the fetch stage. The master side is the fetch unit; the slave side is the
// surrounding core / memory / test environment.
//
// Decode handshake: a transfer happens on every rising clk edge where
// dec_valid && dec_ready. While dec_valid && !dec_ready, dec_instr and dec_pc
// hold their values. dec_valid drops without a transfer only when a redirect
// or reset flushes the buffer. dec_ready may be driven independently of
// dec_valid.
interface fetch_unit_if #(
  parameter int N_REDIR = 2
);
  logic [N_REDIR-1:0]    redir_valid;
  logic [32*N_REDIR-1:0] redir_pc;
  logic                  imem_req;
  logic [31:0]           imem_addr;
  logic [31:0]           imem_rdata;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [31:0]           dec_instr;
  logic [31:0]           dec_pc;
  logic                  misalign_exc;
  logic [31:0]           misalign_pc;

  modport master (
    input  redir_valid, redir_pc, imem_rdata, dec_ready,
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
           misalign_exc, misalign_pc
  );

  modport slave (
    output redir_valid, redir_pc, imem_rdata, dec_ready,
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
           misalign_exc, misalign_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one read per cycle
// to a synchronous instruction memory (one cycle latency), buffers returned
// instructions with their PC in a small FIFO and hands them to decode.
// Any redirect flushes the FIFO and discards the in-flight response.
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets (sets misalign_exc/misalign_pc and stalls fetch until the next
// aligned redirect). Without it, targets have bits [1:0] cleared and the
// misalign outputs are tied to zero.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2,
  parameter int          N_REDIR    = 2
) (
  input logic        clk,
  input logic        rst,
  fetch_unit_if.master bus
);

  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = $clog2(IBUF_DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          exc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_pc    [IBUF_DEPTH];
  logic [31:0]   buf_instr [IBUF_DEPTH];

  logic          redirect;
  logic          pop;
  logic          issue;
  logic [31:0]   tgt_raw;
  logic [31:0]   tgt_pc;
  logic [CW:0]   occupancy;

`ifdef FETCH_ALIGN_CHECK_EN
  logic [31:0]   misalign_pc_q;
  logic          tgt_misaligned;
`endif

  // Redirect target select: walk from the highest index down so the lowest
  // set index is the last (winning) assignment.
  always_comb begin
    tgt_raw = '0;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) tgt_raw = bus.redir_pc[32*i +: 32];
    end
  end

  assign redirect = |bus.redir_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_pc         = tgt_raw;
  assign tgt_misaligned = (tgt_raw[1:0] != 2'b00);
`else
  assign tgt_pc         = tgt_raw & 32'hFFFF_FFFC;
`endif

  // A request is only issued if its response is guaranteed a FIFO slot,
  // counting the response already in flight and this cycle's pop.
  assign pop       = (count != '0) && bus.dec_ready;
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = !rst && !exc && !redirect &&
                     (occupancy < (CW+1)'(IBUF_DEPTH));

  // PC, FIFO pointers/count, in-flight tracking and exception state.
  // A redirect takes priority over both push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      exc         <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_pc_q <= '0;
`endif
    end else if (redirect) begin
      pc       <= tgt_pc;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt_misaligned) begin
        exc           <= 1'b1;
        misalign_pc_q <= tgt_raw;
      end else begin
        exc <= 1'b0;
      end
`endif
    end else begin
      if (inflight) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(inflight) - CW'(pop);
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

  // FIFO storage: capture the memory response tagged with its PC unless a
  // redirect or reset kills it this cycle.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && inflight) begin
      buf_pc[wr_ptr]    <= inflight_pc;
      buf_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.dec_valid = (count != '0);
  // Storage is not reset; gating keeps the head outputs at zero when empty.
  assign bus.dec_instr = bus.dec_valid ? buf_instr[rd_ptr] : '0;
  assign bus.dec_pc    = bus.dec_valid ? buf_pc[rd_ptr]    : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.misalign_exc = exc;
  assign bus.misalign_pc  = misalign_pc_q;
`else
  assign bus.misalign_exc = 1'b0;
  assign bus.misalign_pc  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Instruction memory returns
// addr ^ 32'hA5A5_0000 one cycle after each request. Expected {pc, instr}
// pairs are queued by the stimulus; a negedge monitor pops and compares every
// decode transfer.
module tb_fetch_unit;

  logic clk;
  logic rst;

  int n_pass;
  int n_total;
  logic [63:0] exp_q[$];

  fetch_unit_if #(.N_REDIR(2)) bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IBUF_DEPTH(2),
    .N_REDIR   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model, one cycle read latency.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? (bus.imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(4 * k);
      exp_q.push_back({a, a ^ 32'hA5A5_0000});
    end
  endtask

  task automatic redirect(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1);
    bus.redir_valid = v;
    bus.redir_pc    = {t1, t0};
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst === 1'b0 && bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_transfer: got pc %h instr %h expected no transfer",
                 bus.dec_pc, bus.dec_instr);
      end else begin
        e = exp_q.pop_front();
        if ({bus.dec_pc, bus.dec_instr} === e) n_pass++;
        else $display("FAIL dec_transfer: got pc %h instr %h expected pc %h instr %h",
                      bus.dec_pc, bus.dec_instr, e[63:32], e[31:0]);
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus.dec_ready   = 1'b1;
    bus.redir_valid = 2'b00;
    bus.redir_pc    = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_dec_instr", bus.dec_instr, 32'd0);
    check("rst_dec_pc", bus.dec_pc, 32'd0);
    check("rst_misalign_exc", 32'(bus.misalign_exc), 32'd0);
    check("rst_misalign_pc", bus.misalign_pc, 32'd0);

    // Release: first request at RESET_PC, dec_valid from cycle 2, no gaps
    tick();
    rst = 1'b0;
    push_seq(32'h0, 64);
    @(negedge clk);
    check("c0_imem_req", 32'(bus.imem_req), 32'd1);
    check("c0_imem_addr", bus.imem_addr, 32'h0);
    check("c0_dec_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("c1_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("c1_imem_addr", bus.imem_addr, 32'h4);
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      check("stream_valid", 32'(bus.dec_valid), 32'd1);
    end

    // Stall 6 cycles: buffer fills, requests stop, head (pc 0x20) holds
    tick();
    bus.dec_ready = 1'b0;
    @(negedge clk);
    check("stall_first_req", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("stall_imem_req", 32'(bus.imem_req), 32'd0);
      check("stall_dec_valid", 32'(bus.dec_valid), 32'd1);
      check("stall_dec_pc", bus.dec_pc, 32'h20);
      check("stall_dec_instr", bus.dec_instr, 32'hA5A5_0020);
    end
    tick();
    bus.dec_ready = 1'b1;
    @(negedge clk);
    check("release_imem_req", 32'(bus.imem_req), 32'd1);
    check("release_imem_addr", bus.imem_addr, 32'h28);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("resume_valid", 32'(bus.dec_valid), 32'd1);
    end

    // Two simultaneous redirects: src0 (0x100) wins, 2 bubbles
    tick();
    redirect(2'b11, 32'h100, 32'h200);
    @(negedge clk);
    check("redir_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    redirect(2'b00, 32'h0, 32'h0);
    exp_q.delete();
    push_seq(32'h100, 16);
    @(negedge clk);
    check("redir_t1_req", 32'(bus.imem_req), 32'd1);
    check("redir_t1_addr", bus.imem_addr, 32'h100);
    check("redir_t1_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_t2_valid", 32'(bus.dec_valid), 32'd0);
    check("redir_t2_addr", bus.imem_addr, 32'h104);
    tick();
    @(negedge clk);
    check("redir_t3_valid", 32'(bus.dec_valid), 32'd1);
    repeat (3) tick();

    // Full FIFO, pop and redirect (src1 only, 0x300) in the same cycle
    bus.dec_ready = 1'b0;
    repeat (3) tick();
    bus.dec_ready = 1'b1;
    redirect(2'b10, 32'h500, 32'h300);
    @(negedge clk);
    check("full_redir_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    redirect(2'b00, 32'h0, 32'h0);
    exp_q.delete();
    push_seq(32'h300, 16);
    @(negedge clk);
    check("full_redir_t1_valid", 32'(bus.dec_valid), 32'd0);
    check("full_redir_t1_addr", bus.imem_addr, 32'h300);
    tick();
    @(negedge clk);
    check("full_redir_t2_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("full_redir_t3_valid", 32'(bus.dec_valid), 32'd1);
    repeat (3) tick();

    // Redirect mid-stream with a response in flight (src0, 0x400)
    redirect(2'b01, 32'h400, 32'h600);
    @(negedge clk);
    check("flight_redir_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    redirect(2'b00, 32'h0, 32'h0);
    exp_q.delete();
    push_seq(32'h400, 16);
    @(negedge clk);
    check("flight_redir_t1_valid", 32'(bus.dec_valid), 32'd0);
    check("flight_redir_t1_addr", bus.imem_addr, 32'h400);
    tick();
    @(negedge clk);
    check("flight_redir_t2_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("flight_redir_t3_valid", 32'(bus.dec_valid), 32'd1);
    repeat (2) tick();

    // Reset mid-operation: one entry buffered, one in flight
    rst = 1'b1;
    bus.dec_ready = 1'b0;
    @(negedge clk);
    check("midrst_imem_req", 32'(bus.imem_req), 32'd0);
    tick();
    rst = 1'b0;
    bus.dec_ready = 1'b1;
    exp_q.delete();
    push_seq(32'h0, 16);
    @(negedge clk);
    check("midrst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("midrst_dec_pc", bus.dec_pc, 32'd0);
    check("midrst_dec_instr", bus.dec_instr, 32'd0);
    check("midrst_imem_req_after", 32'(bus.imem_req), 32'd1);
    check("midrst_imem_addr", bus.imem_addr, 32'h0);
    tick();
    @(negedge clk);
    check("midrst_t2_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("midrst_t3_valid", 32'(bus.dec_valid), 32'd1);
    repeat (2) tick();

    // Misaligned redirect target 0x102
    redirect(2'b01, 32'h102, 32'h0);
    @(negedge clk);
    check("mis_redir_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    redirect(2'b00, 32'h0, 32'h0);
    exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    check("mis_exc", 32'(bus.misalign_exc), 32'd1);
    check("mis_pc", bus.misalign_pc, 32'h102);
    check("mis_dec_valid", 32'(bus.dec_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("mis_hold_req", 32'(bus.imem_req), 32'd0);
      tick();
      @(negedge clk);
    end
    tick();
    redirect(2'b01, 32'h200, 32'h0);
    @(negedge clk);
    check("mis_clear_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    redirect(2'b00, 32'h0, 32'h0);
    push_seq(32'h200, 16);
    @(negedge clk);
    check("mis_clear_req", 32'(bus.imem_req), 32'd1);
    check("mis_clear_addr", bus.imem_addr, 32'h200);
    check("mis_clear_exc", 32'(bus.misalign_exc), 32'd0);
`else
    push_seq(32'h100, 16);
    @(negedge clk);
    check("align_force_req", 32'(bus.imem_req), 32'd1);
    check("align_force_addr", bus.imem_addr, 32'h100);
    check("align_force_exc", 32'(bus.misalign_exc), 32'd0);
    check("align_force_mpc", bus.misalign_pc, 32'd0);
`endif
    tick();
    @(negedge clk);
    check("after_mis_t2_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    @(negedge clk);
    check("after_mis_t3_valid", 32'(bus.dec_valid), 32'd1);
    repeat (3) tick();

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
